uart_tx_arbiter: RTL

Round-robin, packet-atomic arbiter that shares the single UART transmit byte path between NUM_REQ requesters in the CLK288MHZ domain. It sits between the requester blocks (loopback echo, status reporter, debug dump, ...) and the TX serializer fed by the TX baud generator. Once a requester is granted, it holds the grant until its packet's last byte is accepted. A stall watchdog reclaims the path if a granted requester stops supplying bytes mid-packet.

---
 rtl/uart_tx_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-atomic arbiter that shares one UART TX byte path between NUM_REQ requesters.
// Latency: request seen in IDLE at cycle n gives grant/busy at n+1; one byte per cycle after that.
// Backpressure: txReady passes straight through to the owner's reqReady; a stalled owner is aborted after TIMEOUT idle cycles.
//
// Ports:
//   CLK288MHZ, reset      - clock, asynchronous active-high reset
//   reqValid/Data/Last    - per-requester byte stream (requester i at reqData[i*DATA_W +: DATA_W])
//   reqReady              - byte accepted from requester i when reqValid[i] && reqReady[i]
//   txData/txValid/txReady- byte stream towards the serializer
//   grant, busy           - one-hot current owner (0 when idle), high while transferring
//   abortPulse, abortId   - one-cycle watchdog abort strobe and the aborted owner's index (held)
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic                        CLK288MHZ,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          reqValid,
    input  logic [NUM_REQ*DATA_W-1:0]   reqData,
    input  logic [NUM_REQ-1:0]          reqLast,
    output logic [NUM_REQ-1:0]          reqReady,
    output logic [DATA_W-1:0]           txData,
    output logic                        txValid,
    input  logic                        txReady,
    output logic [NUM_REQ-1:0]          grant,
    output logic                        busy,
    output logic                        abortPulse,
    output logic [$clog2(NUM_REQ)-1:0]  abortId
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(TIMEOUT + 1);

    typedef enum logic {ST_IDLE, ST_XFER} state_t;

    state_t           r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [IDW-1:0]   r_gidx;
    logic [IDW-1:0]   r_last_grant;
    logic [CW-1:0]    r_stall_cnt;
    logic             r_abort_pulse;
    logic [IDW-1:0]   r_abort_id;

    logic             w_own_vld;
    logic             w_own_last;
    logic [DATA_W-1:0] w_own_dat;
    logic             w_hs;
    logic             w_win_vld;
    logic [IDW-1:0]   w_win_idx;

    // Owner's byte stream, selected by the registered grant index.
    assign w_own_vld  = reqValid[r_gidx];
    assign w_own_last = reqLast[r_gidx];
    assign w_own_dat  = reqData[r_gidx*DATA_W +: DATA_W];

    assign busy       = (r_state == ST_XFER);
    assign grant      = r_grant;
    assign txValid    = busy && w_own_vld;
    assign txData     = busy ? w_own_dat : '0;
    // r_grant is zero in IDLE, so nobody is ready there.
    assign reqReady   = r_grant & {NUM_REQ{txReady}};
    assign w_hs       = txValid && txReady;
    assign abortPulse = r_abort_pulse;
    assign abortId    = r_abort_id;

    // Round-robin pick: first valid requester above the last owner, wrapping.
    // Scanning from the far end downward lets the nearest candidate overwrite the others.
    always_comb begin
        logic [IDW-1:0] w_j;
        w_win_vld = |reqValid;
        w_win_idx = '0;
        w_j       = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            w_j = IDW'((int'(r_last_grant) + i) % NUM_REQ);
            if (reqValid[w_j]) begin
                w_win_idx = w_j;
            end
        end
    end

    always_ff @(posedge CLK288MHZ or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_grant       <= '0;
            r_gidx        <= '0;
            r_last_grant  <= IDW'(NUM_REQ - 1);
            r_stall_cnt   <= '0;
            r_abort_pulse <= 1'b0;
            r_abort_id    <= '0;
        end else begin
            r_abort_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_win_vld) begin
                        r_grant     <= NUM_REQ'(1) << w_win_idx;
                        r_gidx      <= w_win_idx;
                        r_stall_cnt <= '0;
                        r_state     <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (w_hs) begin
                        r_stall_cnt <= '0;
                        if (w_own_last) begin
                            r_state      <= ST_IDLE;
                            r_grant      <= '0;
                            r_last_grant <= r_gidx;
                        end
                    end else if (!w_own_vld) begin
                        // The TIMEOUT-th idle cycle aborts; serializer stalls with a
                        // valid owner neither count nor clear.
                        if (r_stall_cnt == CW'(TIMEOUT - 1)) begin
                            r_state       <= ST_IDLE;
                            r_grant       <= '0;
                            r_last_grant  <= r_gidx;
                            r_abort_pulse <= 1'b1;
                            r_abort_id    <= r_gidx;
                            r_stall_cnt   <= '0;
                        end else begin
                            r_stall_cnt <= r_stall_cnt + CW'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
